sel_decode: RTL and testbench
=============================

SEL_DECODE -- requirements
Module: sel_decode

Interface
REQ-001 SHALL have parameter STABLE_CYCLES, default 4, giving the number of consecutive CLK cycles a synchronized SEL code must hold before it qualifies; legal range is 1 to 255.
REQ-002 SHALL have port CLK  in  1  system clock; all state changes on its rising edge.
REQ-003 SHALL have port RST  in  1  asynchronous active-low reset.
REQ-004 SHALL have port SEL  in  3  one-hot selection code from the button-driven chooser, asynchronous to CLK.
REQ-005 SHALL have port IDX  out  2  encoded selection: 0 for none, 1 for 001, 2 for 010, 3 for 100.
REQ-006 SHALL have port VALID  out  1  high while IDX holds a qualified nonzero selection.
REQ-007 SHALL have port CHG  out  1  one-cycle pulse on any change of the {IDX,VALID} pair.
REQ-008 SHALL have port ERR  out  1  high while the last qualified code was illegal (two or more bits set).

Function
REQ-009 SHALL pass SEL through a two-flop synchronizer (S1, S2); all other logic SHALL use only S2.
REQ-010 SHALL hold a 3-bit candidate register CAND and a counter CNT, at least clog2(STABLE_CYCLES)+1 bits wide.
REQ-011 SHALL implement the states SETTLE, HOLD and FAULT.
REQ-012 In any state, when S2 != CAND, SHALL load CAND<=S2 and CNT<=0 and go to SETTLE; IDX, VALID and ERR SHALL keep their values.
REQ-013 In SETTLE with S2==CAND and CNT < STABLE_CYCLES-1, SHALL increment CNT.
REQ-014 In SETTLE with S2==CAND and CNT==STABLE_CYCLES-1, SHALL qualify CAND on that edge.
REQ-015 On qualifying a legal code (000, 001, 010 or 100), SHALL:
- load IDX and VALID per REQ-005 and REQ-006, with VALID=0 for 000;
- clear ERR;
- go to HOLD.
REQ-016 On qualifying an illegal code, SHALL:
- set ERR=1 and VALID=0;
- leave IDX unchanged;
- go to FAULT.
REQ-017 SHALL assert CHG for exactly the one cycle after an edge on which {IDX,VALID} changed value; requalifying the same legal code SHALL NOT pulse CHG.
REQ-018 In HOLD and FAULT with S2==CAND, SHALL keep all outputs stable and keep CNT unchanged.
REQ-019 Latency: with SEL changed and held stable, outputs SHALL update on rising edge STABLE_CYCLES+3, counting the first edge that samples the new SEL as edge 1.
REQ-020 A SEL excursion shorter than STABLE_CYCLES+1 cycles that returns to the held code SHALL produce no change on IDX, VALID, ERR or CHG.
REQ-021 Leaving FAULT SHALL require a new legal code to qualify; ERR SHALL clear on the edge that code qualifies.

Reset
REQ-022 While RST=0, SHALL asynchronously force the following and go to SETTLE:
- S1, S2, CAND = 000;
- CNT = 0;
- IDX = 0, VALID = 0, CHG = 0, ERR = 0.
REQ-023 After RST release with SEL=000, qualifying 000 SHALL NOT pulse CHG.
REQ-024 Asserting RST mid-SETTLE or mid-pulse SHALL abort qualification and any pending CHG.

Verification (STABLE_CYCLES=4)
REQ-025 Reset with SEL=000 held for 20 cycles -> IDX=0, VALID=0, ERR=0; CHG never asserts.
REQ-026 SEL 000->001 held -> on edge 7: IDX=1, VALID=1, single-cycle CHG.
REQ-027 SEL sequence 001, 010, 100, 000, each held 10 cycles -> IDX 1, 2, 3, 0; VALID drops on 000; exactly 4 CHG pulses.
REQ-028 From qualified 010, SEL=100 for 2 cycles then back to 010 -> IDX stays 2; no CHG.
REQ-029 From qualified 010, SEL=011 held, then 100 -> ERR=1, VALID=0, IDX=2 with one CHG; then ERR=0, IDX=3, VALID=1 with one CHG.
REQ-030 RST low for 1 cycle during SETTLE of 100 -> all outputs 0 immediately without waiting for CLK; with SEL=000 after release, no CHG.

Source files
------------

// File: rtl/sel_decode.sv
// Debounced decoder for a one-hot selection code arriving asynchronously.
// Emits an encoded index, validity, change pulse and illegal-code flag.
module sel_decode #(
  parameter int unsigned STABLE_CYCLES = 4
) (
  input  logic       CLK,
  input  logic       RST,
  input  logic [2:0] SEL,
  output logic [1:0] IDX,
  output logic       VALID,
  output logic       CHG,
  output logic       ERR
);

  localparam int unsigned     CntW   = $clog2(STABLE_CYCLES) + 1;
  localparam logic [CntW-1:0] CntMax = CntW'(STABLE_CYCLES - 1);

  typedef enum logic [1:0] {StSettle, StHold, StFault} state_e;

  state_e          state_q, state_d;
  logic [2:0]      s1_q, s2_q;
  logic [2:0]      cand_q, cand_d;
  logic [CntW-1:0] cnt_q, cnt_d;
  logic [1:0]      idx_q, idx_d;
  logic            valid_q, valid_d;
  logic            err_q, err_d;
  logic            chg_q, chg_d;
  logic            legal;
  logic [1:0]      code_idx;

  always_comb begin
    legal    = 1'b1;
    code_idx = 2'd0;
    case (cand_q)
      3'b000:  code_idx = 2'd0;
      3'b001:  code_idx = 2'd1;
      3'b010:  code_idx = 2'd2;
      3'b100:  code_idx = 2'd3;
      default: legal = 1'b0;
    endcase
  end

  always_comb begin
    state_d = state_q;
    cand_d  = cand_q;
    cnt_d   = cnt_q;
    idx_d   = idx_q;
    valid_d = valid_q;
    err_d   = err_q;
    if (s2_q != cand_q) begin
      // Any movement restarts qualification; outputs hold their last value.
      cand_d  = s2_q;
      cnt_d   = '0;
      state_d = StSettle;
    end else if (state_q == StSettle) begin
      if (cnt_q < CntMax) begin
        cnt_d = cnt_q + CntW'(1);
      end else if (legal) begin
        idx_d   = code_idx;
        valid_d = (cand_q != 3'b000);
        err_d   = 1'b0;
        state_d = StHold;
      end else begin
        valid_d = 1'b0;
        err_d   = 1'b1;
        state_d = StFault;
      end
    end
    chg_d = ({idx_d, valid_d} != {idx_q, valid_q});
  end

  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      s1_q    <= 3'b000;
      s2_q    <= 3'b000;
      cand_q  <= 3'b000;
      cnt_q   <= '0;
      state_q <= StSettle;
      idx_q   <= 2'd0;
      valid_q <= 1'b0;
      err_q   <= 1'b0;
      chg_q   <= 1'b0;
    end else begin
      s1_q    <= SEL;
      s2_q    <= s1_q;
      cand_q  <= cand_d;
      cnt_q   <= cnt_d;
      state_q <= state_d;
      idx_q   <= idx_d;
      valid_q <= valid_d;
      err_q   <= err_d;
      chg_q   <= chg_d;
    end
  end

  assign IDX   = idx_q;
  assign VALID = valid_q;
  assign ERR   = err_q;
  assign CHG   = chg_q;

endmodule

// File: tb/tb_sel_decode.sv
// Bench for sel_decode: directed scenarios plus random SEL streams against a
// run-length reference model of the synchronized code.
module tb_sel_decode;

  localparam int SC = 4;

  logic       CLK;
  logic       RST;
  logic [2:0] SEL;
  logic [1:0] IDX;
  logic       VALID;
  logic       CHG;
  logic       ERR;

  int n_cmp = 0;
  int n_bad = 0;

  // Reference model state: last two SEL samples, current run of identical
  // synchronized values, and the expected outputs.
  logic [2:0] m_s1, m_s2, m_last;
  int         m_run;
  logic [1:0] m_idx;
  logic       m_valid, m_err, m_chg;

  sel_decode #(.STABLE_CYCLES(SC)) dut (
    .CLK  (CLK),
    .RST  (RST),
    .SEL  (SEL),
    .IDX  (IDX),
    .VALID(VALID),
    .CHG  (CHG),
    .ERR  (ERR)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  task automatic model_reset();
    m_s1 = 3'b000; m_s2 = 3'b000; m_last = 3'b000;
    m_run = 1;  // reset acts as the load of candidate 000
    m_idx = 2'd0; m_valid = 1'b0; m_err = 1'b0; m_chg = 1'b0;
  endtask

  task automatic do_reset();
    @(negedge CLK);
    RST = 1'b0;
    SEL = 3'b000;
    model_reset();
    repeat (2) @(posedge CLK);
    #2 RST = 1'b1;
  endtask

  // Drive one SEL value for one cycle; advance the model; return 1ns after the edge.
  task automatic step(input logic [2:0] s);
    logic [2:0] seen;
    logic [2:0] old;
    @(negedge CLK);
    SEL = s;
    @(posedge CLK);
    seen = m_s2; m_s2 = m_s1; m_s1 = s;
    if (seen == m_last) m_run++;
    else begin m_run = 1; m_last = seen; end
    old = {m_idx, m_valid};
    if (m_run == SC + 1) begin
      if ($countones(seen) > 1) begin
        m_err = 1'b1; m_valid = 1'b0;
      end else begin
        m_err = 1'b0; m_valid = (seen != 3'b000); m_idx = 2'd0;
        for (int i = 0; i < 3; i++) if (seen[i]) m_idx = 2'(i + 1);
      end
    end
    m_chg = ({m_idx, m_valid} != old);
    #1;
  endtask

  task automatic test_reset();
    do_reset();
    n_cmp++;
    if ({IDX, VALID, ERR, CHG} !== 5'b0) begin
      n_bad++; $display("FAIL reset_state: got %b want 00000", {IDX, VALID, ERR, CHG});
    end
    for (int c = 0; c < 20; c++) begin
      step(3'b000);
      n_cmp++;
      if ({IDX, VALID, ERR, CHG} !== 5'b0) begin
        n_bad++; $display("FAIL reset_idle cyc %0d: got %b want 00000", c, {IDX, VALID, ERR, CHG});
      end
    end
  endtask

  task automatic test_first_select();
    for (int e = 1; e <= 8; e++) begin
      step(3'b001);
      n_cmp++;
      if ({IDX, VALID, ERR, CHG} !== {m_idx, m_valid, m_err, m_chg}) begin
        n_bad++; $display("FAIL first_model edge %0d: got %b want %b", e,
                          {IDX, VALID, ERR, CHG}, {m_idx, m_valid, m_err, m_chg});
      end
      if (e == 6) begin
        n_cmp++;
        if ({IDX, VALID} !== 3'b000) begin
          n_bad++; $display("FAIL first_early edge 6: got %b want 000", {IDX, VALID});
        end
      end
      if (e == 7) begin
        n_cmp++;
        if ({IDX, VALID, ERR, CHG} !== 5'b01101) begin
          n_bad++; $display("FAIL first_edge7: got %b want 01101", {IDX, VALID, ERR, CHG});
        end
      end
      if (e == 8) begin
        n_cmp++;
        if (CHG !== 1'b0) begin
          n_bad++; $display("FAIL first_chg_width: got %b want 0", CHG);
        end
      end
    end
  endtask

  task automatic test_sequence();
    logic [2:0] codes [4];
    logic [1:0] want_idx [4];
    int         pulses;
    codes = '{3'b001, 3'b010, 3'b100, 3'b000};
    want_idx = '{2'd1, 2'd2, 2'd3, 2'd0};
    pulses = 0;
    do_reset();
    for (int k = 0; k < 4; k++) begin
      for (int c = 0; c < 10; c++) begin
        step(codes[k]);
        if (CHG === 1'b1) pulses++;
        n_cmp++;
        if ({IDX, VALID, ERR, CHG} !== {m_idx, m_valid, m_err, m_chg}) begin
          n_bad++; $display("FAIL seq_model code %b cyc %0d: got %b want %b", codes[k], c,
                            {IDX, VALID, ERR, CHG}, {m_idx, m_valid, m_err, m_chg});
        end
      end
      n_cmp++;
      if ({IDX, VALID} !== {want_idx[k], (k != 3)}) begin
        n_bad++; $display("FAIL seq_out code %b: got %b want %b", codes[k], {IDX, VALID},
                          {want_idx[k], (k != 3)});
      end
    end
    n_cmp++;
    if (pulses != 4) begin
      n_bad++; $display("FAIL seq_pulses: got %0d want 4", pulses);
    end
  endtask

  task automatic test_glitch();
    logic [2:0] pat [22];
    for (int c = 0; c < 22; c++) pat[c] = (c >= 10 && c < 12) ? 3'b100 : 3'b010;
    for (int c = 0; c < 22; c++) begin
      step(pat[c]);
      if (c >= 10) begin
        n_cmp++;
        if ({IDX, VALID, ERR, CHG} !== 5'b10100) begin
          n_bad++; $display("FAIL glitch cyc %0d: got %b want 10100", c, {IDX, VALID, ERR, CHG});
        end
      end
    end
  endtask

  task automatic test_fault();
    int pulses;
    for (int c = 0; c < 10; c++) step(3'b010);
    pulses = 0;
    for (int c = 0; c < 10; c++) begin
      step(3'b011);
      if (CHG === 1'b1) pulses++;
    end
    n_cmp++;
    if ({IDX, VALID, ERR} !== 4'b1001 || pulses != 1) begin
      n_bad++; $display("FAIL fault_enter: got %b/%0d want 1001/1", {IDX, VALID, ERR}, pulses);
    end
    pulses = 0;
    for (int c = 0; c < 10; c++) begin
      step(3'b100);
      if (CHG === 1'b1) pulses++;
    end
    n_cmp++;
    if ({IDX, VALID, ERR} !== 4'b1110 || pulses != 1) begin
      n_bad++; $display("FAIL fault_exit: got %b/%0d want 1110/1", {IDX, VALID, ERR}, pulses);
    end
  endtask

  task automatic test_async_reset();
    for (int c = 0; c < 10; c++) step(3'b010);
    for (int c = 0; c < 3; c++) step(3'b100);
    n_cmp++;
    if ({IDX, VALID} !== 3'b101) begin
      n_bad++; $display("FAIL areset_pre: got %b want 101", {IDX, VALID});
    end
    #2 RST = 1'b0;
    #1;
    n_cmp++;
    if ({IDX, VALID, ERR, CHG} !== 5'b0) begin
      n_bad++; $display("FAIL areset_async: got %b want 00000", {IDX, VALID, ERR, CHG});
    end
    SEL = 3'b000;
    model_reset();
    @(posedge CLK);
    #2 RST = 1'b1;
    for (int c = 0; c < 20; c++) begin
      step(3'b000);
      n_cmp++;
      if ({IDX, VALID, ERR, CHG} !== 5'b0) begin
        n_bad++; $display("FAIL areset_after cyc %0d: got %b want 00000", c, {IDX, VALID, ERR, CHG});
      end
    end
  endtask

  task automatic test_random();
    logic [2:0] legal [4];
    logic [2:0] code;
    int         hold;
    legal = '{3'b000, 3'b001, 3'b010, 3'b100};
    do_reset();
    for (int seg = 0; seg < 150; seg++) begin
      if ($urandom_range(0, 9) < 7) code = legal[$urandom_range(0, 3)];
      else code = 3'($urandom_range(0, 7));
      hold = $urandom_range(1, 9);
      for (int c = 0; c < hold; c++) begin
        step(code);
        n_cmp++;
        if ({IDX, VALID, ERR, CHG} !== {m_idx, m_valid, m_err, m_chg}) begin
          n_bad++; $display("FAIL random seg %0d code %b: got %b want %b", seg, code,
                            {IDX, VALID, ERR, CHG}, {m_idx, m_valid, m_err, m_chg});
        end
      end
    end
  endtask

  initial begin
    RST = 1'b0;
    SEL = 3'b000;
    model_reset();
    test_reset();
    test_first_select();
    test_sequence();
    test_glitch();
    test_fault();
    test_async_reset();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
